// File: rtl/lsu_stage_pkg.sv
// Shared types and helpers for the load/store unit stage.
package lsu_stage_pkg;

    typedef enum logic [1:0] {
        LSU_W = 2'd0,
        LSU_H = 2'd1,
        LSU_B = 2'd2
    } lsu_type;

    typedef enum logic [1:0] {
        LSU_IDLE        = 2'd0,
        LSU_REQ         = 2'd1,
        LSU_WAIT_RVALID = 2'd2
    } lsu_state;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic isMisaligned(input lsu_type lsuType, input logic [1:0] addrLo);
        logic misaligned;
        misaligned = 1'b0;
        case (lsuType)
            LSU_H:   misaligned = addrLo[0];
            LSU_W:   misaligned = (addrLo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replication, load extraction and extension.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  lsu_type     i_type,
    input  logic        i_signExt,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_addrLo, 3'b000};
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = w_shifted;
        case (i_type)
            LSU_H: begin
                o_be    = 4'b0011 << i_addrLo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signExt & w_shifted[15]}}, w_shifted[15:0]};
            end
            LSU_B: begin
                o_be    = 4'b0001 << i_addrLo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signExt & w_shifted[7]}}, w_shifted[7:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = w_shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: captures one issued memory op, runs the gnt/rvalid bus handshake,
// and returns an aligned, extended load result with done/err completion pulses.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int unsigned RVALID_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        data_we_i,
    input  lsu_type     lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [4:0]  rf_waddr_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] rf_wdata_o,
    output logic [4:0]  rf_waddr_o,
    output logic        rf_we_o,
    output logic        done_o,
    output logic        err_o
);

    lsu_state    r_state;
    lsu_state    w_stateNext;
    lsu_type     r_type;
    logic        r_signExt;
    logic [1:0]  r_addrLo;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdog;

    logic        r_dataReq;
    logic        r_dataWe;
    logic [31:0] r_dataAddr;
    logic [3:0]  r_dataBe;
    logic [31:0] r_dataWdata;
    logic [31:0] r_rfWdata;
    logic [4:0]  r_rfWaddr;
    logic        r_rfWe;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_complete;
    logic        w_timeout;
    lsu_type     w_alignType;
    logic        w_alignSign;
    logic [1:0]  w_alignAddrLo;
    logic [3:0]  w_be;
    logic [31:0] w_wdataRep;
    logic [31:0] w_rdataExt;

    assign ready_o      = (r_state == LSU_IDLE);
    assign w_accept     = req_i & ready_o;
    assign w_misaligned = isMisaligned(lsu_type_i, lsu_addr_i[1:0]);

    // While idle the aligner steers the incoming op; afterwards it decodes the captured one.
    assign w_alignType   = (r_state == LSU_IDLE) ? lsu_type_i       : r_type;
    assign w_alignSign   = (r_state == LSU_IDLE) ? lsu_sign_ext_i   : r_signExt;
    assign w_alignAddrLo = (r_state == LSU_IDLE) ? lsu_addr_i[1:0]  : r_addrLo;

    lsu_align u_align (
        .i_type    (w_alignType),
        .i_signExt (w_alignSign),
        .i_addrLo  (w_alignAddrLo),
        .i_wdata   (lsu_wdata_i),
        .i_rdata   (data_rdata_i),
        .o_be      (w_be),
        .o_wdata   (w_wdataRep),
        .o_rdata   (w_rdataExt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept && !w_misaligned) begin
                    w_stateNext = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (data_gnt_i) begin
                    w_stateNext = LSU_WAIT_RVALID;
                end
            end
            LSU_WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    w_stateNext = LSU_IDLE;
                    w_complete  = 1'b1;
                end else if ((RVALID_TIMEOUT != 0) && ((r_wdog + 32'd1) == RVALID_TIMEOUT)) begin
                    w_stateNext = LSU_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: begin
                w_stateNext = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_type      <= LSU_W;
            r_signExt   <= 1'b0;
            r_addrLo    <= 2'b00;
            r_waddr     <= 5'd0;
            r_wdog      <= 32'd0;
            r_dataReq   <= 1'b0;
            r_dataWe    <= 1'b0;
            r_dataAddr  <= 32'd0;
            r_dataBe    <= 4'd0;
            r_dataWdata <= 32'd0;
            r_rfWdata   <= 32'd0;
            r_rfWaddr   <= 5'd0;
            r_rfWe      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rfWe <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_accept) begin
                r_type      <= lsu_type_i;
                r_signExt   <= lsu_sign_ext_i;
                r_addrLo    <= lsu_addr_i[1:0];
                r_waddr     <= rf_waddr_i;
                r_dataWe    <= data_we_i;
                r_dataAddr  <= {lsu_addr_i[31:2], 2'b00};
                r_dataBe    <= w_be;
                r_dataWdata <= w_wdataRep;
                if (w_misaligned) begin
                    r_done <= 1'b1;
                    r_err  <= 1'b1;
                end else begin
                    r_dataReq <= 1'b1;
                end
            end

            if ((r_state == LSU_REQ) && data_gnt_i) begin
                r_dataReq <= 1'b0;
                r_wdog    <= 32'd0;
            end

            if (r_state == LSU_WAIT_RVALID) begin
                r_wdog <= r_wdog + 32'd1;
            end

            // Loads always refresh the result registers; the write strobe is suppressed on error or x0.
            if (w_complete) begin
                r_done <= 1'b1;
                r_err  <= data_err_i;
                if (!r_dataWe) begin
                    r_rfWdata <= w_rdataExt;
                    r_rfWaddr <= r_waddr;
                    r_rfWe    <= !data_err_i && (r_waddr != 5'd0);
                end
            end

            if (w_timeout) begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
            end
        end
    end

    assign data_req_o   = r_dataReq;
    assign data_we_o    = r_dataWe;
    assign data_addr_o  = r_dataAddr;
    assign data_be_o    = r_dataBe;
    assign data_wdata_o = r_dataWdata;
    assign rf_wdata_o   = r_rfWdata;
    assign rf_waddr_o   = r_rfWaddr;
    assign rf_we_o      = r_rfWe;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit directly downstream of the issue stage.
- Accepts one memory operation at a time: the issue request, write enable, write data and RF destination, plus the address computed by the ALU.
- Drives the data-memory request/grant/rvalid bus. Aligns bytes and halves, then sign- or zero-extends load data.
- Produces a one-cycle RF write for loads and a done/err pulse for every accepted operation.

Parameters:
- RVALID_TIMEOUT, 255: max cycles in WAIT_RVALID before a bus error is forced; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  1  operation valid from issue
- ready_o  out  1  high only in IDLE; accept = req_i & ready_o
- data_we_i  in  1  1 = store, 0 = load
- lsu_type_i  in  pkg::lsu_type  LSU_W / LSU_H / LSU_B
- lsu_sign_ext_i  in  1  sign-extend loads (LB/LH)
- lsu_addr_i  in  32  byte address from ALU
- lsu_wdata_i  in  32  store data (rs2)
- rf_waddr_i  in  5  load destination
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  response valid
- data_err_i  in  1  response error, qualified by rvalid
- data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-replicated store data
- data_rdata_i  in  32  read data
- rf_wdata_o  out  32  extended load result
- rf_waddr_o  out  5  load destination
- rf_we_o  out  1  one-cycle RF write strobe
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse, coincident with done_o

Behaviour:
- Reset values: state=IDLE; ready_o=1; data_req_o, data_we_o, rf_we_o, done_o, err_o=0; data_addr_o, data_be_o, data_wdata_o, rf_wdata_o, rf_waddr_o=0; watchdog=0.
- All inputs are registered on accept; later changes on the issue-side inputs are ignored until the next accept.
- Misalignment check on accept: H with addr[0]=1, or W with addr[1:0]!=0.
  - Misaligned: no bus request; next cycle done_o=err_o=1, rf_we_o=0; back to IDLE.
- Byte enables and write data:
  - W: be=4'b1111.
  - H: be=4'b0011 << addr[1:0]; wdata={2{wdata[15:0]}}.
  - B: be=4'b0001 << addr[1:0]; wdata={4{wdata[7:0]}}.
  - Byte enables are driven for loads too.
- FSM:
  - IDLE --accept, aligned--> REQ. data_req_o rises the cycle after accept.
  - REQ: data_req_o and all data_* outputs held stable until data_gnt_i. On gnt: data_req_o=0 next cycle, go to WAIT_RVALID, watchdog cleared.
  - WAIT_RVALID: watchdog increments each cycle. On data_rvalid_i: go to IDLE and pulse done_o next cycle.
    - Store: rf_we_o=0.
    - Load without error: rf_we_o=1 unless rf_waddr=0.
    - Any data_err_i: err_o=1, rf_we_o=0.
  - Watchdog == RVALID_TIMEOUT (when nonzero) without rvalid: done_o=err_o=1, rf_we_o=0, go to IDLE. A late rvalid arriving in IDLE is ignored.
- Gnt and rvalid in the same cycle while in REQ: that rvalid is not consumed (gnt-then-rvalid protocol); a bench must not generate it.
- Load extraction: shifted = rdata >> (8*addr[1:0]).
  - B: 8 bits, extended per lsu_sign_ext_i.
  - H: 16 bits, extended per lsu_sign_ext_i.
  - W: unchanged.
- rf_wdata_o and rf_waddr_o hold their values until the next load completes; rf_we_o, done_o and err_o are strictly single-cycle.
- Reset mid-operation (any state): return to IDLE with reset values; the outstanding transaction is abandoned and a later rvalid is ignored.
- Minimum latency, accept to done, with immediate gnt and rvalid: 3 cycles.

Decomposition:
- pkg additions:
  - typedef enum lsu_type {LSU_W, LSU_H, LSU_B}.
  - typedef enum lsu_state {LSU_IDLE, LSU_REQ, LSU_WAIT_RVALID}.
- One combinational sub-module, lsu_align: byte enables, write replication and load extraction/extension.
- FSM, capture registers and watchdog stay in lsu_stage.

Test Plan:
- SW 0xDEADBEEF @0x100, gnt after 2 cycles, rvalid next -> be=1111, addr=0x100, we=1, req held through wait, done_o=1, rf_we_o=0.
- LB signed @0x203, rdata=0x80xxxxxx -> be=1000, rf_wdata_o=0xFFFFFF80, rf_we_o=1 to rf_waddr_i=5; LBU same -> 0x00000080.
- LH @0x102, rdata=0x1234ABCD signed -> be=1100, rf_wdata_o=0x00001234; SH 0x0000BEEF @0x102 -> wdata=0xBEEFBEEF.
- LW @0x101 -> no data_req_o, done_o=err_o=1 next cycle; LW to x0 -> done_o=1, rf_we_o=0.
- RVALID_TIMEOUT=4, gnt given, no rvalid -> err_o pulse exactly 4 cycles into WAIT_RVALID; late rvalid ignored, ready_o=1.
- rst_i asserted in REQ -> data_req_o=0 next cycle, ready_o=1; rvalid with data_err_i=1 on a load -> err_o=1, rf_we_o=0.
